// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the framed serial byte receiver and its bench.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // True when data plus parity bit has the intended parity (even when odd = 0).
  // Unused upper bits must be zero; they do not affect the XOR reduction.
  function automatic logic parity_ok(input logic [31:0] data, input logic pbit, input logic odd);
    return ((^data) ^ pbit ^ odd) == 1'b0;
  endfunction

endpackage

// File: rtl/serial_byte_rx.sv
// Framed, bit-strobed serial receiver: start, DATA_W data bits LSB-first,
// optional parity, stop. One serial bit is consumed per bit_valid cycle.
//
// state  | meaning
// IDLE   | line idle, waiting for a start bit (0)
// DATA   | shifting in data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking the stop bit, delivering the byte or flagging a frame error
module serial_byte_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bit_valid,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              pbit_q, pbit_d;
  logic [DATA_W-1:0] data_d;
  logic              valid_d, perr_d, ferr_d;

  // Next-state and datapath decode; nothing advances unless bit_valid is high.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    pbit_d  = pbit_q;
    data_d  = data_out;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    if (bit_valid) begin
      unique case (state_q)
        IDLE: begin
          if (serial_in == LINE_START) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shreg_d = {serial_in, shreg_q[DATA_W-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = PARITY_EN ? PARITY : STOP;
        end
        PARITY: begin
          pbit_d  = serial_in;
          state_d = STOP;
        end
        STOP: begin
          // A 0 stop bit is a frame error only; it never doubles as a start bit.
          if (serial_in == LINE_IDLE) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            perr_d  = PARITY_EN && !parity_ok(32'(shreg_q), pbit_q, PARITY_ODD);
          end else begin
            ferr_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      pbit_q     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      pbit_q     <= pbit_d;
      data_out   <= data_d;
      data_valid <= valid_d;
      parity_err <= perr_d;
      frame_err  <= ferr_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_serial_byte_rx.sv
// Scoreboard bench for serial_byte_rx: stimulus pushes expected pulses,
// an independent monitor pops and compares them when the DUT reports one.
module tb_serial_byte_rx;

  localparam bit ODD = 1'b0;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       bit_valid = 1'b0;
  logic       serial_in = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err, busy;

  typedef struct {
    bit         is_ferr;
    logic [7:0] data;
    bit         perr;
    int         due;
  } exp_t;

  exp_t       sbq[$];
  exp_t       got;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] model_out = 8'h00;

  serial_byte_rx #(.DATA_W(8), .PARITY_EN(1'b1), .PARITY_ODD(ODD)) dut (
    .clock      (clock),
    .reset      (reset),
    .bit_valid  (bit_valid),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One qualified bit, then gap cycles where bit_valid is low and the line is noise.
  task automatic put_bit(input logic b, input int gap);
    bit_valid = 1'b1;
    serial_in = b;
    tick();
    bit_valid = 1'b0;
    repeat (gap) begin
      serial_in = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop, input int gap);
    exp_t e;
    put_bit(1'b0, gap);
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < 8; i++) put_bit(d[i], gap);
    put_bit(pbit, gap);
    e.due = cyc + 1;
    if (stop) begin
      e.is_ferr = 1'b0;
      e.data    = d;
      e.perr    = (pbit != 1'(($countones(d) % 2) ^ int'(ODD)));
      model_out = d;
    end else begin
      e.is_ferr = 1'b1;
      e.data    = model_out;
      e.perr    = 1'b0;
    end
    sbq.push_back(e);
    put_bit(stop, 0);
    chk("busy_after_stop", busy, 0);
  endtask

  function automatic logic good_parity(input logic [7:0] d);
    return 1'(($countones(d) % 2) ^ int'(ODD));
  endfunction

  // Monitor: every reported pulse must match the oldest expected event.
  always @(negedge clock) begin
    if (!reset) begin
      if (parity_err && !data_valid) chk("perr_without_valid", 1, 0);
      if (data_valid || frame_err) begin
        chk("pulse_exclusive", 32'(data_valid & frame_err), 0);
        if (sbq.size() == 0) begin
          chk("unexpected_pulse", {data_valid, frame_err}, 0);
        end else begin
          got = sbq.pop_front();
          chk("pulse_kind_ferr", frame_err, got.is_ferr);
          chk("pulse_kind_valid", data_valid, !got.is_ferr);
          chk("data_out", data_out, got.data);
          chk("parity_err", parity_err, got.perr);
          chk("pulse_cycle", cyc, got.due);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_valid", data_valid, 0);
    chk("reset_perr", parity_err, 0);
    chk("reset_ferr", frame_err, 0);

    // 1: 0xA5 with correct even parity, bit_valid every cycle
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    repeat (2) tick();

    // 2: 0x10, bit_valid every third cycle
    send_frame(8'h10, 1'b1, 1'b1, 2);
    repeat (3) tick();
    chk("t2_busy_low", busy, 0);

    // 3: 0x01 with wrong parity still delivers
    send_frame(8'h01, 1'b0, 1'b1, 0);
    repeat (2) tick();

    // 4: 0x3C with a 0 stop bit; the 0 must not start a new frame
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    put_bit(1'b1, 0);
    chk("t4_no_restart", busy, 0);
    chk("t4_data_held", data_out, 8'h01);
    repeat (2) tick();

    // 5: reset after four data bits aborts silently
    put_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) put_bit(1'b1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_out = 8'h00;
    chk("t5_busy", busy, 0);
    chk("t5_data_out", data_out, 0);
    chk("t5_valid", data_valid, 0);
    chk("t5_ferr", frame_err, 0);
    tick();
    send_frame(8'h80, 1'b1, 1'b1, 0);
    repeat (2) tick();

    // 6: start level with bit_valid low is ignored, then back-to-back frames
    serial_in = 1'b0;
    bit_valid = 1'b0;
    repeat (3) tick();
    chk("t6_idle_hold", busy, 0);
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 0);
    repeat (2) tick();

    // Randomized frames: random data, gaps, occasional bad parity or stop bit
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic       p;
      d = 8'($urandom);
      p = good_parity(d);
      if ($urandom_range(0, 4) == 0) p = ~p;
      send_frame(d, p, ($urandom_range(0, 7) != 0), $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) begin
        bit_valid = 1'($urandom_range(0, 1));
        serial_in = 1'b1;
        tick();
      end
      bit_valid = 1'b0;
    end

    repeat (4) tick();
    chk("sb_drain", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_byte_rx.md
Name: serial_byte_rx

Overview:
- Upstream stage of the byte MSB-index encoder.
- Receives a framed, bit-strobed serial stream: start bit, DATA_W data bits LSB-first, optional parity bit, stop bit.
- Presents the assembled byte on data_out for the encoder's data_in, with a one-cycle data_valid pulse and error flags.
- No oversampling: one serial bit is consumed per cycle in which bit_valid is high.

Parameters:
- DATA_W, 8, number of data bits per frame (≥2).
- PARITY_EN, 1, 1 = parity bit present between the last data bit and the stop bit.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0).

Ports:
- clock  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- bit_valid  input  1  qualifies serial_in for this cycle.
- serial_in  input  1  serial line; idle level 1, start level 0.
- data_out  output  DATA_W  last successfully framed byte; feeds encoder data_in.
- data_valid  output  1  one-cycle pulse: new byte on data_out.
- parity_err  output  1  one-cycle pulse with data_valid when parity mismatches.
- frame_err  output  1  one-cycle pulse when the stop bit is 0.
- busy  output  1  high while a frame is in progress (state ≠ IDLE).

Behaviour:
- Reset (synchronous, active-high, clock is the only clock):
  - state = IDLE, bit counter = 0, shift register = 0.
  - data_out = 0, data_valid = 0, parity_err = 0, frame_err = 0, busy = 0.
  - Reset mid-frame aborts the frame; no pulse is ever produced for an aborted frame.
- bit_valid = 0: all state holds and serial_in is ignored. Pulses still deassert after their single cycle.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions below happen only on cycles with bit_valid = 1.
  - IDLE: serial_in = 0 → DATA, cnt = 0. serial_in = 1 → stay.
  - DATA: shreg ← {serial_in, shreg[DATA_W-1:1]}, cnt++. When cnt = DATA_W-1 → PARITY if PARITY_EN, else STOP.
  - PARITY: capture pbit → STOP.
  - STOP, serial_in = 1:
    - data_out ← shreg, data_valid ← 1.
    - parity_err ← PARITY_EN & (^shreg ^ pbit ^ PARITY_ODD).
    - → IDLE.
  - STOP, serial_in = 0:
    - frame_err ← 1, data_valid ← 0, data_out unchanged.
    - → IDLE. The 0 is NOT reinterpreted as a new start bit.
- Latency:
  - data_valid / frame_err are registered on the edge that samples the stop bit, so they are high in the following cycle, for exactly one cycle.
  - The byte appears on data_out in that same cycle.
- Parity error does not suppress delivery: data_out updates and data_valid pulses together with parity_err.
- data_out holds between frames. The encoder samples every cycle, so a held value is harmless.
- Back-to-back frames: a start bit on the bit_valid immediately after the stop bit (even the next clock) is accepted.
- busy is decoded from the state register. It is high from the cycle after the start bit is sampled up to and including the cycle the stop bit is sampled.
- Counter width: $clog2(DATA_W). No wrap is possible because the counter is reset on entry to DATA.

Decomposition:
- Shared package serial_rx_pkg holds:
  - rx_state_t enum {IDLE, DATA, PARITY, STOP};
  - constants LINE_IDLE = 1'b1 and LINE_START = 1'b0;
  - function parity_ok(data, pbit, odd), for reuse by the bench scoreboard.
- Single module; no sub-module is warranted.

Test Plan:
1. Reset, then frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1) with bit_valid every cycle → one data_valid pulse with data_out = 0xA5 and parity_err = 0; downstream encoder reports msb = 7.
2. Frame 0x10 (parity 1) with bit_valid high every 3rd cycle only → exactly one data_valid, in the cycle after the stop-bit edge; data_out = 0x10; busy low afterwards.
3. Frame 0x01 with parity bit 0 (wrong for even) → data_valid = 1, data_out = 0x01, parity_err = 1 in the same cycle.
4. Frame 0x3C with stop bit 0 → frame_err pulse, data_valid stays 0, data_out remains 0x01; the FSM returns to IDLE and does not start a new frame on that 0.
5. Reset asserted after 4 data bits → next cycle: busy = 0, all outputs 0, no pulse. A following full frame 0x80 (parity 1) is received correctly.
6. serial_in = 0 while bit_valid = 0 in IDLE → stays IDLE. Then two back-to-back frames 0x5A, 0xFF with no idle gap → two data_valid pulses, in order, with correct values.
